// File: rtl/ddr_pkg.sv
// Shared definitions for the DDR user-port controllers: command opcodes, arbiter
// states and requester IDs.
package ddr_pkg;

  localparam logic [2:0] CMD_READ  = 3'b001;
  localparam logic [2:0] CMD_WRITE = 3'b000;

  localparam logic REQ_R = 1'b0;
  localparam logic REQ_W = 1'b1;

  typedef enum logic [1:0] {
    StWaitCal = 2'd0,
    StIdle    = 2'd1,
    StIssue   = 2'd2,
    StGap     = 2'd3
  } arb_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single slow asynchronous level.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic stage1_q;
  logic stage2_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage1_q <= 1'b0;
      stage2_q <= 1'b0;
    end else begin
      stage1_q <= d;
      stage2_q <= stage1_q;
    end
  end

  assign q = stage2_q;

endmodule

// File: rtl/ddr_cmd_arbiter.sv
// Round-robin arbiter sharing one MCB command port between the display reader (R)
// and the pixel writer (W), with urgent-read priority and a starvation cap.
module ddr_cmd_arbiter
  import ddr_pkg::*;
#(
  parameter int unsigned ADDR_W       = 30,
  parameter int unsigned BL_W         = 6,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_calib_done,
  input  logic              cmd_full,
  input  logic [6:0]        wr_count,
  output logic              cmd_en,
  output logic [2:0]        cmd_instr,
  output logic [BL_W-1:0]   cmd_bl,
  output logic [ADDR_W-1:0] cmd_byte_addr,
  input  logic              r_req,
  input  logic              r_urgent,
  input  logic [ADDR_W-1:0] r_addr,
  input  logic [BL_W-1:0]   r_bl,
  output logic              r_ack,
  input  logic              w_req,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [BL_W-1:0]   w_bl,
  output logic              w_ack,
  output logic              calib_ok,
  output logic              busy
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] StarveMax = SW'(STARVE_LIMIT);

  arb_state_e    state;
  logic [SW-1:0] starve_cnt;
  logic          last_grant;

  logic       r_elig;
  logic       w_elig;
  logic       both_elig;
  logic       winner;
  logic [6:0] w_need;

  sync_2ff u_calib_sync (
    .clk   (clk),
    .reset (reset),
    .d     (mem_calib_done),
    .q     (calib_ok)
  );

  // A write is only eligible once its whole burst is already in the write FIFO.
  always_comb begin
    w_need    = 7'(w_bl) + 7'd1;
    r_elig    = r_req;
    w_elig    = w_req && (wr_count >= w_need);
    both_elig = r_elig && w_elig;

    if ((starve_cnt == StarveMax) && ((last_grant == REQ_R) ? w_elig : r_elig)) begin
      winner = ~last_grant;
    end else if (r_urgent && r_elig) begin
      winner = REQ_R;
    end else if (both_elig) begin
      winner = ~last_grant;
    end else if (r_elig) begin
      winner = REQ_R;
    end else begin
      winner = REQ_W;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= StWaitCal;
      starve_cnt    <= '0;
      last_grant    <= REQ_W;
      cmd_en        <= 1'b0;
      cmd_instr     <= 3'b000;
      cmd_bl        <= '0;
      cmd_byte_addr <= '0;
      r_ack         <= 1'b0;
      w_ack         <= 1'b0;
    end else begin
      unique case (state)
        StWaitCal: begin
          if (calib_ok) state <= StIdle;
        end
        StIdle: begin
          if (!calib_ok) begin
            state <= StWaitCal;
          end else if (!cmd_full && (r_elig || w_elig)) begin
            if (winner == REQ_R) begin
              cmd_instr     <= CMD_READ;
              cmd_bl        <= r_bl;
              cmd_byte_addr <= {r_addr[ADDR_W-1:2], 2'b00};
              r_ack         <= 1'b1;
            end else begin
              cmd_instr     <= CMD_WRITE;
              cmd_bl        <= w_bl;
              cmd_byte_addr <= {w_addr[ADDR_W-1:2], 2'b00};
              w_ack         <= 1'b1;
            end
            cmd_en <= 1'b1;
            if (both_elig && (winner == last_grant)) begin
              if (starve_cnt != StarveMax) starve_cnt <= starve_cnt + 1'b1;
            end else begin
              starve_cnt <= SW'(1);
            end
            last_grant <= winner;
            state      <= StIssue;
          end
        end
        StIssue: begin
          cmd_en <= 1'b0;
          r_ack  <= 1'b0;
          w_ack  <= 1'b0;
          state  <= StGap;
        end
        StGap: begin
          state <= StIdle;
        end
        default: state <= StWaitCal;
      endcase
    end
  end

  assign busy = (state != StIdle);

endmodule
